// File: rtl/cell_processor.sv
// ---------------------------------------------------------------------------
// cell_processor
//
// Pipelined per-channel pixel arithmetic on the center pixels of two 3x3 RGB
// neighbourhoods. One operation is accepted every clock. The result of inputs
// sampled at edge N is on processedPixel after edge N+3.
//
// Pipeline:
//   stage 1  : input registers (cellA, cellB, userInputA, opcode)
//   stage 2a : GRAY sum and BLUR adder tree complete, registered with operands
//   stage 2b : opcode select / clamp, registered result
//   stage 3  : processedPixel register
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset, clears every stage
//   cellA          in   216-bit neighbourhood A, pixel k at [24k+23:24k]
//   cellB          in   216-bit neighbourhood B (center pixel only is used)
//   userInputA     in   8-bit scalar operand U
//   opcode         in   4-bit operation select
//   processedPixel out  24-bit registered result, R=[23:16] G=[15:8] B=[7:0]
//
// Configuration:
//   CELLPROC_BLUR_EN  defined -> opcode 8 is the 3x3 [1 2 1;2 4 2;1 2 1] blur.
//                     undefined -> no kernel adder tree, opcode 8 outputs 0.
// ---------------------------------------------------------------------------
module cell_processor #(
    parameter int PIX_W      = 24,
    parameter int CELL_PIX   = 9,
    parameter int CELL_DEPTH = CELL_PIX * PIX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CELL_DEPTH-1:0] cellA,
    input  logic [CELL_DEPTH-1:0] cellB,
    input  logic [7:0]            userInputA,
    input  logic [3:0]            opcode,
    output logic [PIX_W-1:0]      processedPixel
);

    localparam int CTR = 4;

    // ---------------- stage 1 ----------------
    logic [CELL_DEPTH-1:0] cell_a_q;
    logic [CELL_DEPTH-1:0] cell_b_q;
    logic [7:0]            user_q;
    logic [3:0]            op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_a_q <= '0;
            cell_b_q <= '0;
            user_q   <= '0;
            op_q     <= '0;
        end else begin
            cell_a_q <= cellA;
            cell_b_q <= cellB;
            user_q   <= userInputA;
            op_q     <= opcode;
        end
    end

    logic [PIX_W-1:0] ac_d;
    logic [PIX_W-1:0] bc_d;
    logic [9:0]       gray_sum_d;

    assign ac_d = cell_a_q[CTR*PIX_W +: PIX_W];
    assign bc_d = cell_b_q[CTR*PIX_W +: PIX_W];

    // R + 2G + B fits in 10 bits (max 1020).
    assign gray_sum_d = {2'b00, ac_d[23:16]} + {1'b0, ac_d[15:8], 1'b0} + {2'b00, ac_d[7:0]};

    // Only the center of B ever matters.
    logic unused_cell_b;
    assign unused_cell_b = ^{cell_b_q[CELL_DEPTH-1:(CTR+1)*PIX_W], cell_b_q[CTR*PIX_W-1:0]};

`ifdef CELLPROC_BLUR_EN
    // Corners weight 1, edges (odd k) weight 2, center weight 4; max sum 4080.
    function automatic logic [7:0] blur_chan(input logic [CELL_DEPTH-1:0] cell, input int ch);
        logic [11:0] acc;
        logic [11:0] pix;
        acc = '0;
        for (int k = 0; k < CELL_PIX; k++) begin
            pix = {4'b0000, cell[k*PIX_W + ch*8 +: 8]};
            if (k == CTR)
                acc = acc + (pix << 2);
            else if ((k % 2) == 1)
                acc = acc + (pix << 1);
            else
                acc = acc + pix;
        end
        return acc[11:4];
    endfunction

    logic [PIX_W-1:0] blur_d;
    assign blur_d = {blur_chan(cell_a_q, 2), blur_chan(cell_a_q, 1), blur_chan(cell_a_q, 0)};
`else
    logic unused_cell_a;
    assign unused_cell_a = ^{cell_a_q[CELL_DEPTH-1:(CTR+1)*PIX_W], cell_a_q[CTR*PIX_W-1:0]};
`endif

    // ---------------- stage 2a ----------------
    logic [3:0]       op2_q;
    logic [PIX_W-1:0] ac2_q;
    logic [PIX_W-1:0] bc2_q;
    logic [7:0]       user2_q;
    logic [7:0]       gray2_q;
`ifdef CELLPROC_BLUR_EN
    logic [PIX_W-1:0] blur2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op2_q   <= '0;
            ac2_q   <= '0;
            bc2_q   <= '0;
            user2_q <= '0;
            gray2_q <= '0;
`ifdef CELLPROC_BLUR_EN
            blur2_q <= '0;
`endif
        end else begin
            op2_q   <= op_q;
            ac2_q   <= ac_d;
            bc2_q   <= bc_d;
            user2_q <= user_q;
            gray2_q <= gray_sum_d[9:2];
`ifdef CELLPROC_BLUR_EN
            blur2_q <= blur_d;
`endif
        end
    end

    // Per-channel ops 0..6; anything else yields 0 here.
    function automatic logic [7:0] chan_op(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] u);
        logic [8:0] sum_ab;
        logic [8:0] sum_au;
        logic [7:0] res;
        sum_ab = {1'b0, a} + {1'b0, b};
        sum_au = {1'b0, a} + {1'b0, u};
        case (op)
            4'd0:    res = a;
            4'd1:    res = sum_ab[8] ? 8'hFF : sum_ab[7:0];
            4'd2:    res = (a > b) ? (a - b) : 8'h00;
            4'd3:    res = sum_au[8] ? 8'hFF : sum_au[7:0];
            4'd4:    res = (a > u) ? (a - u) : 8'h00;
            4'd5:    res = ~a;
            4'd6:    res = sum_ab[8:1];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // ---------------- stage 2b ----------------
    logic [PIX_W-1:0] result_d;
    logic [PIX_W-1:0] result_q;

    always_comb begin
        result_d = '0;
        case (op2_q)
            4'd7: result_d = {3{gray2_q}};
            4'd9: result_d = (gray2_q >= user2_q) ? 24'hFFFFFF : 24'h000000;
`ifdef CELLPROC_BLUR_EN
            4'd8: result_d = blur2_q;
`endif
            default: begin
                for (int ch = 0; ch < 3; ch++)
                    result_d[ch*8 +: 8] = chan_op(op2_q, ac2_q[ch*8 +: 8], bc2_q[ch*8 +: 8], user2_q);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            result_q <= '0;
        else
            result_q <= result_d;
    end

    // ---------------- stage 3 ----------------
    logic [PIX_W-1:0] pixel_q;

    always_ff @(posedge clk) begin
        if (rst)
            pixel_q <= '0;
        else
            pixel_q <= result_q;
    end

    assign processedPixel = pixel_q;

endmodule

// File: tb/tb_cell_processor.sv
module tb_cell_processor;

    logic         clk = 1'b0;
    logic         rst;
    logic [215:0] cellA;
    logic [215:0] cellB;
    logic [7:0]   userInputA;
    logic [3:0]   opcode;
    logic [23:0]  processedPixel;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int W_K[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    cell_processor dut (
        .clk           (clk),
        .rst           (rst),
        .cellA         (cellA),
        .cellB         (cellB),
        .userInputA    (userInputA),
        .opcode        (opcode),
        .processedPixel(processedPixel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [215:0] make_cell(input logic [23:0] center, input logic [23:0] ring);
        logic [215:0] c;
        for (int k = 0; k < 9; k++)
            c[k*24 +: 24] = (k == 4) ? center : ring;
        return c;
    endfunction

    // Reference: the spec's rules on plain integers.
    function automatic logic [23:0] ref_pixel(input logic [215:0] a, input logic [215:0] b,
                                              input logic [7:0] u, input logic [3:0] op);
        int ca[3];
        int av, bv, uv, y, r, s;
        logic [23:0] res;
        for (int c = 0; c < 3; c++) ca[c] = int'(a[96 + 8*c +: 8]);
        y   = (ca[2] + 2*ca[1] + ca[0]) / 4;
        uv  = int'(u);
        res = '0;
        for (int c = 0; c < 3; c++) begin
            av = ca[c];
            bv = int'(b[96 + 8*c +: 8]);
            case (op)
                4'd0: r = av;
                4'd1: r = (av + bv > 255) ? 255 : av + bv;
                4'd2: r = (av > bv) ? av - bv : 0;
                4'd3: r = (av + uv > 255) ? 255 : av + uv;
                4'd4: r = (av > uv) ? av - uv : 0;
                4'd5: r = 255 - av;
                4'd6: r = (av + bv) / 2;
                4'd7: r = y;
                4'd8: begin
`ifdef CELLPROC_BLUR_EN
                    s = 0;
                    for (int k = 0; k < 9; k++) s += W_K[k] * int'(a[24*k + 8*c +: 8]);
                    r = s / 16;
`else
                    s = 0;
                    r = s;
`endif
                end
                4'd9: r = (y >= uv) ? 255 : 0;
                default: r = 0;
            endcase
            res[8*c +: 8] = r[7:0];
        end
        return res;
    endfunction

    // Model: three in-flight results plus the visible output.
    logic [23:0] pipe_m[$] = '{24'h0, 24'h0, 24'h0};
    logic [23:0] out_m = 24'h0;

    task automatic do_cycle(input logic r, input logic [215:0] a, input logic [215:0] b,
                            input logic [7:0] u, input logic [3:0] op);
        rst        = r;
        cellA      = a;
        cellB      = b;
        userInputA = u;
        opcode     = op;
        @(posedge clk);
        if (r) begin
            pipe_m = '{24'h0, 24'h0, 24'h0};
            out_m  = 24'h0;
        end else begin
            out_m = pipe_m.pop_front();
            pipe_m.push_back(ref_pixel(a, b, u, op));
        end
        @(negedge clk);
        check("model", processedPixel, out_m);
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, '0, 8'h00, 4'd0);
    endtask

    task automatic run_op(input string tag, input logic [215:0] a, input logic [215:0] b,
                          input logic [7:0] u, input logic [3:0] op, input logic [23:0] exp);
        do_cycle(1'b0, a, b, u, op);
        idle();
        idle();
        idle();
        check(tag, processedPixel, exp);
    endtask

    initial begin
        logic [215:0] ra, rb;
        logic [23:0]  blur_flat, blur_ctr;

        // Reset then PASS
        do_cycle(1'b1, '0, '0, 8'h00, 4'd0);
        check("reset0", processedPixel, 24'h0);
        do_cycle(1'b1, '0, '0, 8'h00, 4'd0);
        check("reset1", processedPixel, 24'h0);
        do_cycle(1'b0, make_cell(24'h123456, 24'h0), '0, 8'h00, 4'd0);
        check("pass_m0", processedPixel, 24'h0);
        idle();
        check("pass_m1", processedPixel, 24'h0);
        idle();
        check("pass_m2", processedPixel, 24'h0);
        idle();
        check("pass_m3", processedPixel, 24'h123456);

        // Saturation, user operand, gray/threshold
        run_op("add_sat", make_cell(24'hF01080, 24'h0), make_cell(24'h20F080, 24'h0), 8'h00, 4'd1, 24'hFFFFFF);
        run_op("sub_floor", make_cell(24'hF01080, 24'h0), make_cell(24'h20F080, 24'h0), 8'h00, 4'd2, 24'hD00000);
        run_op("bright", make_cell(24'h10F0FF, 24'h0), '0, 8'h20, 4'd3, 24'h30FFFF);
        run_op("dark", make_cell(24'h10F0FF, 24'h0), '0, 8'h20, 4'd4, 24'h00D0DF);
        run_op("gray", make_cell(24'h4080C0, 24'h0), '0, 8'h00, 4'd7, 24'h808080);
        run_op("thresh_eq", make_cell(24'h4080C0, 24'h0), '0, 8'd128, 4'd9, 24'hFFFFFF);
        run_op("thresh_gt", make_cell(24'h4080C0, 24'h0), '0, 8'd129, 4'd9, 24'h000000);

        // Blur
`ifdef CELLPROC_BLUR_EN
        blur_flat = 24'h102030;
        blur_ctr  = 24'h3F3F3F;
`else
        blur_flat = 24'h000000;
        blur_ctr  = 24'h000000;
`endif
        run_op("blur_flat", make_cell(24'h102030, 24'h102030), make_cell(24'hFFFFFF, 24'hFFFFFF), 8'hFF, 4'd8, blur_flat);
        run_op("blur_center", make_cell(24'hFFFFFF, 24'h0), '0, 8'h00, 4'd8, blur_ctr);
        run_op("reserved", make_cell(24'hABCDEF, 24'h123456), make_cell(24'h111111, 24'h0), 8'h55, 4'd12, 24'h0);

        // Back-to-back stream
        ra = make_cell(24'h0A0B0C, 24'h0);
        rb = make_cell(24'h020406, 24'h0);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd0);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd5);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd6);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd15);
        check("stream0", processedPixel, 24'h0A0B0C);
        idle();
        check("stream1", processedPixel, 24'hF5F4F3);
        idle();
        check("stream2", processedPixel, 24'h060709);
        idle();
        check("stream3", processedPixel, 24'h000000);

        // Reset mid-stream discards in-flight work
        do_cycle(1'b0, ra, rb, 8'h00, 4'd1);
        do_cycle(1'b0, ra, rb, 8'h40, 4'd3);
        do_cycle(1'b1, ra, rb, 8'h40, 4'd3);
        check("flush_r", processedPixel, 24'h0);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd0);
        check("flush_1", processedPixel, 24'h0);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd5);
        check("flush_2", processedPixel, 24'h0);
        do_cycle(1'b0, ra, rb, 8'h00, 4'd0);
        check("flush_3", processedPixel, 24'h0);
        idle();
        check("flush_4", processedPixel, 24'h0A0B0C);
        idle();
        check("flush_5", processedPixel, 24'hF5F4F3);

        // Randomized stream against the model
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 9; k++) begin
                ra[k*24 +: 24] = 24'($urandom);
                rb[k*24 +: 24] = 24'($urandom);
            end
            do_cycle(($urandom_range(0, 39) == 0), ra, rb, 8'($urandom), 4'($urandom_range(0, 15)));
        end
        idle();
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
